chaos_key_gen: RTL

Sequential driver and consumer for the single-precision Chen step block. Holds the (x, y, z) trajectory registers and presents them to the combinational step. Each cycle it registers the step's next-state outputs, discards a warm-up transient, then folds low mantissa bits of each new state into a key shift register. Completed keys leave through a valid/ready handshake to the downstream key consumer.

---
 rtl/chaos_key_gen.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/chaos_key_gen.sv
// Chen-trajectory key generator: steps an external combinational step block,
// discards a warm-up transient, then folds XOR'd low mantissa bytes into keys.
module chaos_key_gen #(
    parameter int WARMUP = 100,
    parameter int KEY_W  = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      seed_x,
    input  logic [31:0]      seed_y,
    input  logic [31:0]      seed_z,
    output logic [31:0]      cx,
    output logic [31:0]      cy,
    output logic [31:0]      cz,
    input  logic [31:0]      nx,
    input  logic [31:0]      ny,
    input  logic [31:0]      nz,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             busy,
    output logic             diverge
);

    localparam int                BYTES     = KEY_W / 8;
    localparam int                BCNT_W    = $clog2(BYTES + 1);
    localparam logic [BCNT_W-1:0] BYTE_LAST = BCNT_W'(BYTES - 1);
    localparam logic [15:0]       WARM_LAST = 16'((WARMUP == 0) ? 0 : WARMUP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WARM = 2'd1,
        ST_GEN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // An all-ones exponent field marks Inf or NaN.
    function automatic logic f_is_special(input logic [31:0] v);
        return (v[30:23] == 8'hFF);
    endfunction

    state_t             r_state;
    logic [31:0]        r_cx;
    logic [31:0]        r_cy;
    logic [31:0]        r_cz;
    logic [KEY_W-1:0]   r_key;
    logic               r_valid;
    logic               r_busy;
    logic               r_diverge;
    logic [15:0]        r_warm_cnt;
    logic [BCNT_W-1:0]  r_byte_cnt;

    state_t             w_state_nxt;
    logic               w_load_seed;
    logic               w_step;
    logic               w_shift;
    logic               w_warm_clr;
    logic               w_warm_inc;
    logic               w_byte_clr;
    logic               w_byte_inc;
    logic               w_valid_nxt;
    logic               w_div_nxt;
    logic               w_diverging;
    logic [7:0]         w_fold_byte;
    logic [KEY_W-1:0]   w_key_shift;

    assign w_diverging = f_is_special(nx) | f_is_special(ny) | f_is_special(nz);
    assign w_fold_byte = nx[7:0] ^ ny[7:0] ^ nz[7:0];

    generate
        if (KEY_W == 8) begin : g_key_narrow
            assign w_key_shift = w_fold_byte;
        end else begin : g_key_wide
            assign w_key_shift = {r_key[KEY_W-9:0], w_fold_byte};
        end
    endgenerate

    // Next-state and datapath control decode; stop overrides every other request.
    always_comb begin
        w_state_nxt = r_state;
        w_load_seed = 1'b0;
        w_step      = 1'b0;
        w_shift     = 1'b0;
        w_warm_clr  = 1'b0;
        w_warm_inc  = 1'b0;
        w_byte_clr  = 1'b0;
        w_byte_inc  = 1'b0;
        w_valid_nxt = r_valid;
        w_div_nxt   = r_diverge;
        if (stop && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_load_seed = 1'b1;
                        w_warm_clr  = 1'b1;
                        w_byte_clr  = 1'b1;
                        w_div_nxt   = 1'b0;
                        w_state_nxt = (WARMUP == 0) ? ST_GEN : ST_WARM;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WARM: begin
                    if (w_diverging) begin
                        w_div_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_step     = 1'b1;
                        w_warm_inc = 1'b1;
                        if (r_warm_cnt == WARM_LAST) begin
                            w_state_nxt = ST_GEN;
                        end else begin
                            w_state_nxt = ST_WARM;
                        end
                    end
                end
                ST_GEN: begin
                    if (w_diverging) begin
                        w_div_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_step     = 1'b1;
                        w_shift    = 1'b1;
                        w_byte_inc = 1'b1;
                        if (r_byte_cnt == BYTE_LAST) begin
                            w_state_nxt = ST_HOLD;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_GEN;
                        end
                    end
                end
                ST_HOLD: begin
                    // Next key continues the same trajectory, no re-warm.
                    if (key_ready) begin
                        w_byte_clr  = 1'b1;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_GEN;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Trajectory registers: seeded on start, advanced from the step block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx <= 32'd0;
            r_cy <= 32'd0;
            r_cz <= 32'd0;
        end else if (w_load_seed) begin
            r_cx <= seed_x;
            r_cy <= seed_y;
            r_cz <= seed_z;
        end else if (w_step) begin
            r_cx <= nx;
            r_cy <= ny;
            r_cz <= nz;
        end
    end

    // Key shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
        end else if (w_shift) begin
            r_key <= w_key_shift;
        end
    end

    // Warm-up and byte counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm_cnt <= 16'd0;
            r_byte_cnt <= '0;
        end else begin
            if (w_warm_clr) begin
                r_warm_cnt <= 16'd0;
            end else if (w_warm_inc) begin
                r_warm_cnt <= r_warm_cnt + 16'd1;
            end
            if (w_byte_clr) begin
                r_byte_cnt <= '0;
            end else if (w_byte_inc) begin
                r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
            end
        end
    end

    // Registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_diverge <= 1'b0;
        end else begin
            r_valid   <= w_valid_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_diverge <= w_div_nxt;
        end
    end

    assign cx        = r_cx;
    assign cy        = r_cy;
    assign cz        = r_cz;
    assign key       = r_key;
    assign key_valid = r_valid;
    assign busy      = r_busy;
    assign diverge   = r_diverge;

endmodule
